// File: rtl/jk_encoder_if.sv
// jk_encoder_if: packet request, payload pull and line-state signals of the USB full-speed J/K encoder.
// Revision 1.0
`default_nettype none

interface jk_encoder_if;
  logic tx_start;
  logic bit_in;
  logic bit_last;
  logic bit_ready;
  logic dp_out;
  logic dn_out;
  logic oe;
  logic tx_busy;
  logic tx_done;

  modport master (
    output tx_start, bit_in, bit_last,
    input  bit_ready, dp_out, dn_out, oe, tx_busy, tx_done
  );

  modport slave (
    input  tx_start, bit_in, bit_last,
    output bit_ready, dp_out, dn_out, oe, tx_busy, tx_done
  );
endinterface

`default_nettype wire

// File: rtl/jk_encoder.sv
// jk_encoder: USB full-speed transmit encoder (SYNC, NRZI, bit stuffing, EOP) at 12 Mb/s from a 48 MHz clock.
// Revision 1.0
`default_nettype none

module jk_encoder (
  input  wire logic       clk48,
  input  wire logic       reset,
  jk_encoder_if.slave     bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    PAYLOAD = 3'd2,
    STUFF   = 3'd3,
    EOP_SE0 = 3'd4,
    EOP_J   = 3'd5
  } state_t;

  state_t     state;
  logic [1:0] phase;
  logic [2:0] ones;
  logic [2:0] cnt;
  logic       line;
  logic       last;

  logic in_slot;
  logic sync_more;
  logic stuff_next;
  logic advance;
  logic pull;
  logic data;
  logic line_n;

  // Decisions for the slot boundary; all inputs are stable through phases 2 and 3.
  always_comb begin
    in_slot    = (state == SYNC) || (state == PAYLOAD) || (state == STUFF);
    sync_more  = (state == SYNC) && (cnt != 3'd7);
    stuff_next = (ones == 3'd6);
    advance    = sync_more || stuff_next || !last;
    pull       = in_slot && !sync_more && !stuff_next && !last;
    data       = sync_more ? (cnt == 3'd6) : (stuff_next ? 1'b0 : bus.bit_in);
    line_n     = data ? line : ~line;
  end

  always_ff @(posedge clk48) begin
    bus.tx_done   <= 1'b0;
    bus.bit_ready <= 1'b0;
    if (reset) begin
      state      <= IDLE;
      phase      <= 2'd0;
      ones       <= 3'd0;
      cnt        <= 3'd0;
      line       <= 1'b1;
      last       <= 1'b0;
      bus.dp_out <= 1'b1;
      bus.dn_out <= 1'b0;
      bus.oe     <= 1'b0;
      bus.tx_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          phase <= 2'd0;
          if (bus.tx_start) begin
            // First SYNC bit is a data 0, so the line toggles from J to K immediately.
            state       <= SYNC;
            cnt         <= 3'd0;
            ones        <= 3'd0;
            last        <= 1'b0;
            line        <= 1'b0;
            bus.dp_out  <= 1'b0;
            bus.dn_out  <= 1'b1;
            bus.oe      <= 1'b1;
            bus.tx_busy <= 1'b1;
          end
        end

        SYNC, PAYLOAD, STUFF: begin
          phase <= phase + 2'd1;
          if (phase == 2'd2 && pull)
            bus.bit_ready <= 1'b1;
          if (phase == 2'd3) begin
            if (advance) begin
              line       <= line_n;
              bus.dp_out <= line_n;
              bus.dn_out <= ~line_n;
              ones       <= data ? ones + 3'd1 : 3'd0;
              if (sync_more)
                cnt <= cnt + 3'd1;
              else if (stuff_next)
                state <= STUFF;
              else begin
                state <= PAYLOAD;
                last  <= bus.bit_last;
              end
            end else begin
              state      <= EOP_SE0;
              cnt        <= 3'd0;
              bus.dp_out <= 1'b0;
              bus.dn_out <= 1'b0;
            end
          end
        end

        EOP_SE0: begin
          phase <= phase + 2'd1;
          if (phase == 2'd3) begin
            if (cnt == 3'd1) begin
              state      <= EOP_J;
              bus.dp_out <= 1'b1;
              bus.dn_out <= 1'b0;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end

        EOP_J: begin
          phase <= phase + 2'd1;
          if (phase == 2'd3) begin
            state       <= IDLE;
            ones        <= 3'd0;
            last        <= 1'b0;
            line        <= 1'b1;
            bus.oe      <= 1'b0;
            bus.tx_busy <= 1'b0;
            bus.tx_done <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          phase <= 2'd0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jk_encoder.sv
// tb_jk_encoder: checks jk_encoder line output cycle by cycle against a bit-stream model of the packet.
// Revision 1.0
`default_nettype none

module tb_jk_encoder;
  logic clk48 = 1'b0;
  logic reset;

  jk_encoder_if bus_if();

  jk_encoder dut (
    .clk48 (clk48),
    .reset (reset),
    .bus   (bus_if)
  );

  always #10 clk48 = ~clk48;

  int n_cmp = 0;
  int n_bad = 0;

  // Observation vector: {dp, dn, oe, bit_ready, tx_busy, tx_done}
  localparam logic [5:0] IDLE_V = 6'b100000;

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (dp dn oe rdy busy done)", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] obs();
    return {bus_if.dp_out, bus_if.dn_out, bus_if.oe, bus_if.bit_ready, bus_if.tx_busy, bus_if.tx_done};
  endfunction

  // Sends one packet and compares every cycle with the model. abort_at>0 pulses reset
  // in that cycle; restart_at>0 raises tx_start in that cycle while busy.
  task automatic send(input bit pl[$], input int abort_at, input int restart_at, input string name);
    bit         data[$];
    int         pidx[$];
    logic [5:0] expv[$];
    logic [5:0] tmp;
    int         ones;
    int         idx;
    bit         pulled;
    logic       lref;

    // Bit stream: SYNC 0000_0001 then payload, a 0 after every run of six 1s.
    ones = 0;
    for (int i = 0; i < 8 + pl.size(); i++) begin
      bit b;
      b = (i < 8) ? (i == 7) : pl[i - 8];
      data.push_back(b);
      pidx.push_back(i < 8 ? -1 : i - 8);
      ones = b ? ones + 1 : 0;
      if (ones == 6) begin
        data.push_back(1'b0);
        pidx.push_back(-1);
        ones = 0;
      end
    end

    lref = 1'b1;
    foreach (data[s]) begin
      if (!data[s]) lref = ~lref;
      for (int k = 0; k < 4; k++) expv.push_back({lref, ~lref, 1'b1, 1'b0, 1'b1, 1'b0});
    end
    // The pull for the bit carried in slot s happens in the last cycle of slot s-1.
    foreach (pidx[s]) begin
      if (pidx[s] >= 0) begin
        tmp = expv[4*s - 1];
        tmp[2] = 1'b1;
        expv[4*s - 1] = tmp;
      end
    end
    for (int k = 0; k < 8; k++) expv.push_back(6'b001010);
    for (int k = 0; k < 4; k++) expv.push_back(6'b101010);
    expv.push_back(6'b100001);
    expv.push_back(IDLE_V);

    @(posedge clk48); #1;
    bus_if.tx_start = 1'b1;
    idx = 0;
    bus_if.bit_in   = pl[0];
    bus_if.bit_last = (pl.size() == 1);
    pulled = 1'b0;

    for (int c = 1; c <= expv.size(); c++) begin
      @(posedge clk48); #1;
      bus_if.tx_start = (c == restart_at);
      if (pulled && idx < pl.size() - 1) idx++;
      bus_if.bit_in   = pl[idx];
      bus_if.bit_last = (idx == pl.size() - 1);
      if (abort_at > 0 && c == abort_at + 1) begin
        reset = 1'b0;
        check($sformatf("%s abort c%0d", name, c), obs(), IDLE_V);
        return;
      end
      if (c == abort_at) reset = 1'b1;
      pulled = bus_if.bit_ready;
      check($sformatf("%s c%0d", name, c), obs(), expv[c-1]);
    end
  endtask

  initial begin
    bit q[$];

    reset = 1'b1;
    bus_if.tx_start = 1'b0;
    bus_if.bit_in   = 1'b0;
    bus_if.bit_last = 1'b0;
    repeat (2) @(posedge clk48);
    #1;
    check("reset", obs(), IDLE_V);
    reset = 1'b0;
    @(posedge clk48); #1;
    check("idle", obs(), IDLE_V);

    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(i == 7);
    send(q, 0, 0, "zeros");

    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(1'b1);
    send(q, 0, 0, "ones8");

    q.delete();
    for (int i = 0; i < 7; i++) q.push_back(i != 0);
    send(q, 0, 0, "stuff_last");

    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(1'(($urandom >> i) & 1));
    send(q, 42, 0, "abort");
    send(q, 0, 0, "after_abort");

    send(q, 0, 10, "restart_ignored");
    repeat (3) begin
      @(posedge clk48); #1;
      check("post_restart_idle", obs(), IDLE_V);
    end

    for (int p = 0; p < 12; p++) begin
      int n;
      n = $urandom_range(1, 24);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back($urandom_range(0, 4) != 0);
      send(q, 0, 0, $sformatf("rnd%0d", p));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
